demux_1_4_buf: RTL and testbench

- 1-to-4 demultiplexer with per-channel buffering; the counterpart of the 4:1 selection mux in the health-check datapath.
- Takes one valid/ready sample stream and routes each sample to one of four downstream consumers (sensor/alarm channels), selected by a 2-bit select.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- A wrap-around transfer counter supports health-check bookkeeping.

---
 rtl/demux_1_4_buf_if.sv | 30 +++
 rtl/demux_1_4_buf.sv | 63 ++++++
 tb/tb_demux_1_4_buf.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_4_buf_if.sv
// Handshake bundle for the buffered 1:4 demultiplexer: one upstream sample
// stream in, four independently stalled channel outputs plus a transfer count.
interface demux_1_4_buf_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              E;
    logic              s0;
    logic              s1;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [DATA_W-1:0] out_data3;
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (
        output E, s0, s1, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
    );

    modport slave (
        input  E, s0, s1, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
    );
endinterface

// File: rtl/demux_1_4_buf.sv
// 1-to-4 demultiplexer with a one-entry holding register per channel, so a
// stalled consumer blocks only its own channel; counts accepted samples.
module demux_1_4_buf #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_1_4_buf_if.slave   bus
);

    logic [1:0]        sel_s;
    logic              ready_s;
    logic              accept_s;
    logic [3:0]        wr_s;
    logic [3:0]        drain_s;
    logic [3:0]        full_r;
    logic [DATA_W-1:0] data_r [4];
    logic [CNT_W-1:0]  cnt_r;

    // Ready looks through to the selected consumer so a draining channel takes a new sample with no bubble
    always_comb begin
        sel_s    = {bus.s1, bus.s0};
        ready_s  = bus.E & (~full_r[sel_s] | bus.out_ready[sel_s]);
        accept_s = bus.in_valid & ready_s;
        drain_s  = full_r & bus.out_ready;
        if (accept_s) begin
            wr_s = 4'b0001 << sel_s;
        end else begin
            wr_s = 4'b0000;
        end
    end

    // Channel flags, held samples and the wrapping transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= '0;
            end
            cnt_r <= '0;
        end else begin
            full_r <= wr_s | (full_r & ~drain_s);
            for (int k = 0; k < 4; k++) begin
                if (wr_s[k]) begin
                    data_r[k] <= bus.in_data;
                end
            end
            if (accept_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = full_r;
    assign bus.out_data0 = data_r[0];
    assign bus.out_data1 = data_r[1];
    assign bus.out_data2 = data_r[2];
    assign bus.out_data3 = data_r[3];
    assign bus.xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Bench for demux_1_4_buf: directed table, corner sequences and random traffic
// checked against a per-channel queue model.
module tb_demux_1_4_buf;

    logic clk;
    logic rst_n;

    demux_1_4_buf_if #(.DATA_W(8), .CNT_W(8)) bus ();

    demux_1_4_buf #(.DATA_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference: each channel is a queue of at most one pending sample
    logic [7:0] mq [4][$];
    int         m_cnt;

    logic       cur_e;
    logic [1:0] cur_sel;
    logic       cur_iv;
    logic [7:0] cur_d;
    logic [3:0] cur_ordy;

    typedef struct {
        logic        e;
        logic [1:0]  sel;
        logic        iv;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        x_ready;
        logic [3:0]  x_valid;
        logic [7:0]  x_cnt;
        logic [31:0] x_data;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dout(input int k);
        case (k)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    function automatic logic [31:0] all_data();
        return {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mq[k].delete();
        m_cnt = 0;
    endtask

    // drive one cycle's inputs after the falling edge and compare against the model
    task automatic apply(input logic e, input logic [1:0] sel, input logic iv,
                         input logic [7:0] d, input logic [3:0] ordy);
        @(negedge clk);
        cur_e = e; cur_sel = sel; cur_iv = iv; cur_d = d; cur_ordy = ordy;
        bus.E = e; bus.s0 = sel[0]; bus.s1 = sel[1];
        bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
        #1;
        chk("m_ready", {31'd0, bus.in_ready},
            {31'd0, e & ((mq[sel].size() == 0) | ordy[sel])});
        for (int k = 0; k < 4; k++) begin
            chk("m_valid", {31'd0, bus.out_valid[k]}, {31'd0, mq[k].size() != 0});
            if (mq[k].size() != 0) chk("m_data", {24'd0, dout(k)}, {24'd0, mq[k][0]});
        end
        chk("m_cnt", {24'd0, bus.xfer_cnt}, m_cnt[31:0] & 32'h0000_00FF);
    endtask

    // advance the model across the rising edge
    task automatic commit();
        logic acc;
        @(posedge clk);
        acc = cur_iv & cur_e & ((mq[cur_sel].size() == 0) | cur_ordy[cur_sel]);
        for (int k = 0; k < 4; k++) begin
            if (cur_ordy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
        end
        if (acc) begin
            mq[cur_sel].push_back(cur_d);
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic step(input logic e, input logic [1:0] sel, input logic iv,
                        input logic [7:0] d, input logic [3:0] ordy);
        apply(e, sel, iv, d, ordy);
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_data", all_data(), 32'd0);
        chk("rst_cnt", {24'd0, bus.xfer_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt_before;
        rst_n = 1'b0;
        bus.E = 1'b0; bus.s0 = 1'b0; bus.s1 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 4'b0000;
        model_clear();

        tbl[0]  = '{1'b1, 2'd0, 1'b1, 8'h11, 4'b1111, 1'b1, 4'b0000, 8'd0, 32'h00000000};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 8'h22, 4'b1111, 1'b1, 4'b0001, 8'd1, 32'h00000011};
        tbl[2]  = '{1'b1, 2'd2, 1'b1, 8'h33, 4'b1111, 1'b1, 4'b0010, 8'd2, 32'h00002211};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 8'h44, 4'b1111, 1'b1, 4'b0100, 8'd3, 32'h00332211};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b1000, 8'd4, 32'h44332211};
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 8'h5A, 4'b1101, 1'b1, 4'b0000, 8'd4, 32'h44332211};
        tbl[6]  = '{1'b1, 2'd1, 1'b1, 8'h6B, 4'b1101, 1'b0, 4'b0010, 8'd5, 32'h44335A11};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 8'h00, 4'b1101, 1'b1, 4'b0010, 8'd5, 32'h44335A11};
        tbl[8]  = '{1'b1, 2'd1, 1'b1, 8'h6B, 4'b1111, 1'b1, 4'b0010, 8'd5, 32'h44335A11};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 8'h00, 4'b1101, 1'b0, 4'b0010, 8'd6, 32'h44336B11};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 8'h99, 4'b1111, 1'b0, 4'b0010, 8'd6, 32'h44336B11};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 8'h99, 4'b0000, 1'b0, 4'b0000, 8'd6, 32'h44336B11};

        repeat (2) @(negedge clk);
        #1;
        chk("init_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("init_cnt", {24'd0, bus.xfer_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // routing, backpressure and enable gating from a known state
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].e, tbl[i].sel, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].x_ready});
            chk($sformatf("tbl%0d_valid", i), {28'd0, bus.out_valid}, {28'd0, tbl[i].x_valid});
            chk($sformatf("tbl%0d_cnt", i), {24'd0, bus.xfer_cnt}, {24'd0, tbl[i].x_cnt});
            chk($sformatf("tbl%0d_data", i), all_data(), tbl[i].x_data);
            commit();
        end

        // enable gating with channel 3 pre-filled and stalled
        step(1'b1, 2'd3, 1'b1, 8'h3C, 4'b0000);
        cnt_before = m_cnt;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 2'd3, 1'b1, 8'hC3, (i == 4) ? 4'b1000 : 4'b0000);
            chk("en_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("en_hold3", {31'd0, bus.out_valid[3]}, 32'd1);
            commit();
        end
        apply(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        chk("en_drained3", {31'd0, bus.out_valid[3]}, 32'd0);
        chk("en_cnt", {24'd0, bus.xfer_cnt}, cnt_before[31:0]);
        commit();

        // select change while stalled on a full channel
        step(1'b1, 2'd2, 1'b1, 8'h77, 4'b0000);
        apply(1'b1, 2'd2, 1'b1, 8'h88, 4'b0000);
        chk("sel_stall_ready", {31'd0, bus.in_ready}, 32'd0);
        commit();
        apply(1'b1, 2'd0, 1'b1, 8'h88, 4'b0000);
        chk("sel_switch_ready", {31'd0, bus.in_ready}, 32'd1);
        commit();
        apply(1'b1, 2'd0, 1'b0, 8'h00, 4'b0000);
        chk("sel_v0", {31'd0, bus.out_valid[0]}, 32'd1);
        chk("sel_d0", {24'd0, bus.out_data0}, 32'h88);
        chk("sel_d2", {24'd0, bus.out_data2}, 32'h77);
        commit();

        // reset mid-stream with channel 2 holding A5
        do_reset();
        step(1'b1, 2'd2, 1'b1, 8'hA5, 4'b0000);
        apply(1'b1, 2'd1, 1'b0, 8'h00, 4'b0000);
        chk("pre_rst_d2", {24'd0, bus.out_data2}, 32'hA5);
        do_reset();
        for (int s = 0; s < 4; s++) begin
            apply(1'b1, s[1:0], 1'b0, 8'h00, 4'b0000);
            chk($sformatf("post_rst_ready%0d", s), {31'd0, bus.in_ready}, 32'd1);
            commit();
        end

        // counter wrap: 257 accepted samples into channel 0
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 2'd0, 1'b1, 8'(i * 7 + 1), 4'b0001);
        end
        apply(1'b1, 2'd0, 1'b0, 8'h00, 4'b0001);
        chk("wrap_cnt", {24'd0, bus.xfer_cnt}, 32'd1);
        chk("wrap_last", {24'd0, bus.out_data0}, 32'h01);
        commit();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
